// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: state encoding and sizing helper for the bit-serial subtractor
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Never returns less than 1, so a counter can always be declared from it
    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// full_subtractor: combinational one-bit subtract cell, d = a - b - b_in
import serial_sub_pkg::*;

module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic b_in,
    output logic d,
    output logic b_out
);

    always_comb begin
        d     = a ^ b ^ b_in;
        b_out = (~a & b) | (~(a ^ b) & b_in);
    end

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first bit-serial unsigned a - b with start/done handshake.
// Defining SERIAL_SUB_OVERFLOW_EN adds a registered signed-overflow output.
import serial_sub_pkg::*;

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int CW = clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t             state;
    logic [WIDTH-1:0]   a_sh, b_sh, res, res_nxt;
    logic [CW-1:0]      cnt;
    logic               borrow_ff, d, b_nxt;

    full_subtractor u_fs (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .b_in (borrow_ff),
        .d    (d),
        .b_out(b_nxt)
    );

    assign res_nxt = {d, res[WIDTH-1:1]};

`ifdef SERIAL_SUB_OVERFLOW_EN
    logic a_msb, b_msb;
    always_ff @(posedge clk) begin
        if (rst) begin
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            overflow <= 1'b0;
        end else if (state != SHIFT && start) begin
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
        end else if (state == SHIFT && cnt == LAST) begin
            overflow <= (a_msb ^ b_msb) & (a_msb ^ d);
        end
    end
`endif

    // diff/borrow_out only move on the final bit; res accumulates meanwhile
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            a_sh       <= '0;
            b_sh       <= '0;
            res        <= '0;
            cnt        <= '0;
            borrow_ff  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh      <= a;
                        b_sh      <= b;
                        borrow_ff <= 1'b0;
                        cnt       <= '0;
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    a_sh      <= a_sh >> 1;
                    b_sh      <= b_sh >> 1;
                    res       <= res_nxt;
                    borrow_ff <= b_nxt;
                    cnt       <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        diff       <= res_nxt;
                        borrow_out <= b_nxt;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed scoreboard bench for serial_subtractor (WIDTH=8).
// Honours SERIAL_SUB_OVERFLOW_EN when defined.
module tb_serial_subtractor;

    logic       clk = 0, rst = 1, start = 0;
    logic [7:0] a = 0, b = 0, diff;
    logic       busy, done, borrow_out, overflow;
    int         cyc = 0, n_cmp = 0, n_bad = 0;

    typedef struct {
        logic [7:0] d;
        logic       bo;
        logic       ov;
        int         cyc;
    } exp_t;
    exp_t q[$];

    serial_subtractor #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .diff      (diff),
        .borrow_out(borrow_out)
`ifdef SERIAL_SUB_OVERFLOW_EN
        ,
        .overflow  (overflow)
`endif
    );

`ifndef SERIAL_SUB_OVERFLOW_EN
    assign overflow = 1'b0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && done) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1, expected no pending op (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("diff", diff, e.d);
                check("borrow_out", borrow_out, e.bo);
                check("done_latency", cyc, e.cyc);
                check("busy_at_done", busy, 0);
`ifdef SERIAL_SUB_OVERFLOW_EN
                check("overflow", overflow, e.ov);
`endif
            end
        end
    end

    // Drives start for one edge; callable from between any two edges
    task automatic issue(input logic [7:0] xa, input logic [7:0] xb,
                         input logic [7:0] xd, input logic xbo, input logic xov);
        exp_t e;
        e.d = xd; e.bo = xbo; e.ov = xov; e.cyc = cyc + 9;
        q.push_back(e);
        a = xa; b = xb; start = 1;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) return;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL done_timeout: got no done in 40 cycles, expected a done pulse");
    endtask

    initial begin
        int nb;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_diff", diff, 0);
        check("reset_borrow", borrow_out, 0);

        @(posedge clk); #1;
        issue(8'd5, 8'd3, 8'h02, 0, 0);
        nb = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) break;
            if (busy) nb++;
        end
        check("busy_cycles", nb, 8);

        @(posedge clk); #1;
        issue(8'd3, 8'd5, 8'hFE, 1, 0);
        wait_done();
        @(posedge clk); #1;
        issue(8'h00, 8'h01, 8'hFF, 1, 0);
        wait_done();

        // start mid-SHIFT with different operands must be ignored
        @(posedge clk); #1;
        issue(8'h80, 8'h01, 8'h7F, 0, 1);
        repeat (3) @(posedge clk);
        #1 a = 8'h11; b = 8'h11; start = 1;
        @(posedge clk); #1 start = 0;
        wait_done();
        repeat (3) @(posedge clk);
        #1;

        // back-to-back: restart inside the DONE cycle
        issue(8'h7F, 8'hFF, 8'h80, 1, 1);
        wait_done();
        issue(8'hFF, 8'hFF, 8'h00, 0, 0);
        wait_done();
        @(posedge clk); #1;
        issue(8'h05, 8'h03, 8'h02, 0, 0);
        wait_done();

        // abort mid-operation: no done, outputs cleared
        @(posedge clk); #1;
        a = 8'h80; b = 8'h01; start = 1;
        @(posedge clk); #1 start = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_diff", diff, 0);
        check("abort_borrow", borrow_out, 0);
        check("abort_overflow", overflow, 0);
        repeat (15) @(negedge clk);
        check("pending_ops", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
